sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Two-master, one-slave arbiter for the sram-like bus.
- Masters are the fetch port driven by the pre-IF stage (inst_*) and the MEM-stage load/store port (data_*).
- Slave is the single sram-like port toward the AXI bridge (bus_*).
- Serialises address phases, keeps grants stable while the slave stalls, and returns data_ok/rdata to the owning master in issue order.

Parameters:
- DEPTH, 4: maximum accepted-but-unanswered transactions (owner FIFO entries); power of two, ≥2.
- STARVE_LIMIT, 8: consecutive cycles inst may be refused while requesting before it takes priority over data.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- inst_req  in  1  fetch request
- inst_wr  in  1  fetch write flag (expected 0; forwarded unchanged)
- inst_size  in  2  fetch size
- inst_wstrb  in  4  fetch byte strobes
- inst_addr  in  32  fetch address
- inst_wdata  in  32  fetch write data
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  32  fetch read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data port request, same meaning as inst_*
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata  out  1/1/2/4/32/32  muxed request to slave
- bus_addr_ok  in  1  slave accepted address
- bus_data_ok  in  1  slave response valid (in order)
- bus_rdata  in  32  slave read data

Behaviour:
- Reset (sync):
  - owner FIFO empty, lock_valid=0, starve_cnt=0.
  - Combinational outputs with inputs idle: all *_addr_ok=0, *_data_ok=0, bus_req=0.
- Grant selection (combinational, same cycle):
  - No grant when FIFO full (count==DEPTH), even if bus_data_ok pops that cycle.
  - Otherwise, if lock_valid and the locked master still requests: grant the locked master.
  - Otherwise, if data_req and not (inst_req and starve_cnt==STARVE_LIMIT): grant data.
  - Otherwise, if inst_req: grant inst.
- Bus mux:
  - bus_req = granted master's req; bus_wr/size/wstrb/addr/wdata from the granted master.
  - With no grant: bus_req=0, other bus_* fields driven from data.
- Address handshake:
  - Granted master's addr_ok = bus_addr_ok & bus_req; the other master's addr_ok=0.
  - Handshake occurs at bus_req & bus_addr_ok: push owner ID (0=inst, 1=data) into FIFO.
- Lock:
  - Set: bus_req & ~bus_addr_ok sets lock_valid=1 and lock_id=grantee.
  - Clear: on the handshake, or if the locked master drops req.
  - Purpose: the slave sees the same master until accepted.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle inst_req=1 and inst is not handshaken.
  - Clears on an inst handshake or when inst_req=0.
- Response routing:
  - bus_data_ok with FIFO non-empty: pop head; head==0 → inst_data_ok=1, head==1 → data_data_ok=1, same cycle.
  - inst_rdata = data_rdata = bus_rdata always; only the data_ok qualifies it.
- Simultaneous push/pop in one cycle: count unchanged; head advances and tail advances.
- Combinational paths:
  - Zero-cycle response path: bus_data_ok to *_data_ok is combinational.
  - A push in cycle N is eligible for a pop in cycle N+1 at the earliest.
- Spurious bus_data_ok with FIFO empty: ignored, no pop, no data_ok asserted.
- FIFO pointers: log2(DEPTH) bits with an extra wrap bit; full/empty from pointer compare; wrap-around exact at DEPTH.
- Reset mid-transaction: FIFO and lock cleared next edge; outstanding responses are discarded by the block. Slave quiescence is the bridge's responsibility.

Test Plan:
- Reset, then single inst read to addr 0xbfc00000, bus_addr_ok same cycle, bus_data_ok 2 cycles later with rdata 0x3c1d8000 → inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata=0x3c1d8000; data_* stay 0.
- inst_req and data_req both high, bus_addr_ok=1 every cycle → data handshaken first, inst next. Responses A then B route to data then inst respectively.
- data_req held with bus_addr_ok=0 for 3 cycles, then inst_req rises → bus_addr stays data_addr through acceptance (lock); inst granted the cycle after.
- bus_addr_ok=1, no bus_data_ok, alternating requests → after 4 handshakes both addr_ok=0 and bus_req=0. One bus_data_ok (head=inst) frees a slot; the next grant occurs the following cycle.
- data_req permanently high and inst_req high, bus_addr_ok=1 → after 8 refused cycles inst receives a grant; starve_cnt returns to 0.
- bus_data_ok with empty FIFO → no data_ok. Reset asserted with 2 outstanding → FIFO empty next cycle; a later bus_data_ok produces no data_ok.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if: one sram-like request/response channel.
//   req/wr/size/wstrb/addr/wdata : request fields, driven by the requester
//   addr_ok                      : address phase accepted, driven by the responder
//   data_ok/rdata                : in-order response, driven by the responder
// master modport = requester side, slave modport = responder side.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: two-master (fetch, load/store) to one-slave sram-like arbiter.
// Serialises address phases onto the bus, holds the grant while the slave
// stalls an address, and routes in-order responses back via an owner FIFO.
//   clk, reset : clock, synchronous active-high reset
//   inst       : fetch master channel (slave modport)
//   data       : load/store master channel (slave modport)
//   bus        : channel toward the AXI bridge (master modport)
// addr_ok/data_ok toward the masters are combinational from the bus handshakes.
module sram_like_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_like_arbiter_if.slave    inst,
    sram_like_arbiter_if.slave    data,
    sram_like_arbiter_if.master   bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    // Lock state: which master the slave is currently stalling on.
    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_e;

    lock_e              lock_q;
    lock_e              lock_d;
    logic [PTR_W:0]     wr_ptr_q;
    logic [PTR_W:0]     rd_ptr_q;
    logic [DEPTH-1:0]   owner_q;
    logic [CNT_W-1:0]   starve_q;

    logic               fifo_empty;
    logic               fifo_full;
    logic               starve_sat;
    logic               gnt_inst;
    logic               gnt_data;
    logic               handshake;
    logic               pop;
    logic               head;

    // Owner FIFO status: extra wrap bit distinguishes full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign starve_sat = (starve_q == CNT_W'(STARVE_LIMIT));

    // Grant selection: lock first, then data unless inst is starved.
    // A pop in the same cycle does not free a slot for this cycle's grant.
    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        if (!fifo_full) begin
            if (lock_q == LOCK_INST && inst.req) begin
                gnt_inst = 1'b1;
            end else if (lock_q == LOCK_DATA && data.req) begin
                gnt_data = 1'b1;
            end else if (data.req && !(inst.req && starve_sat)) begin
                gnt_data = 1'b1;
            end else if (inst.req) begin
                gnt_inst = 1'b1;
            end
        end
    end

    // Bus request mux; idle fields follow the data port.
    assign bus.req   = gnt_inst | gnt_data;
    assign bus.wr    = gnt_inst ? inst.wr    : data.wr;
    assign bus.size  = gnt_inst ? inst.size  : data.size;
    assign bus.wstrb = gnt_inst ? inst.wstrb : data.wstrb;
    assign bus.addr  = gnt_inst ? inst.addr  : data.addr;
    assign bus.wdata = gnt_inst ? inst.wdata : data.wdata;

    assign handshake    = bus.req & bus.addr_ok;
    assign inst.addr_ok = gnt_inst & bus.addr_ok;
    assign data.addr_ok = gnt_data & bus.addr_ok;

    // Response routing: responses with no outstanding owner are dropped.
    assign pop          = bus.data_ok & ~fifo_empty;
    assign head         = owner_q[rd_ptr_q[PTR_W-1:0]];
    assign inst.data_ok = pop & ~head;
    assign data.data_ok = pop & head;
    assign inst.rdata   = bus.rdata;
    assign data.rdata   = bus.rdata;

    // Lock next state: a stalled address pins the grantee until accepted
    // or until that master withdraws its request.
    always_comb begin
        lock_d = lock_q;
        if (bus.req) begin
            if (bus.addr_ok) begin
                lock_d = LOCK_NONE;
            end else begin
                lock_d = gnt_data ? LOCK_DATA : LOCK_INST;
            end
        end else begin
            case (lock_q)
                LOCK_INST: if (!inst.req) lock_d = LOCK_NONE;
                LOCK_DATA: if (!data.req) lock_d = LOCK_NONE;
                default:   lock_d = LOCK_NONE;
            endcase
        end
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= LOCK_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Owner FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (handshake) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
            end
        end
    end

    // Owner FIFO storage: 0 = inst, 1 = data.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= '0;
        end else if (handshake) begin
            owner_q[wr_ptr_q[PTR_W-1:0]] <= gnt_data;
        end
    end

    // Starvation counter for refused fetch requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else if (!inst.req || (handshake && gnt_inst)) begin
            starve_q <= '0;
        end else if (!starve_sat) begin
            starve_q <= starve_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed vector table plus a starvation sequence
// for sram_like_arbiter (DEPTH=4, STARVE_LIMIT=8).
module tb_sram_like_arbiter;

    localparam logic [31:0] IA  = 32'hbfc0_0000;
    localparam logic [31:0] DA  = 32'h8000_1000;
    localparam logic [31:0] IWD = 32'h1111_0000;
    localparam logic [31:0] DWD = 32'hdddd_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_like_arbiter_if inst_if ();
    sram_like_arbiter_if data_if ();
    sram_like_arbiter_if bus_if ();

    sram_like_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_if),
        .data  (data_if),
        .bus   (bus_if)
    );

    typedef struct {
        logic        rst;
        logic        ireq;
        logic        dreq;
        logic        baok;
        logic        bdok;
        logic [31:0] brdata;
        logic        e_iaok;
        logic        e_daok;
        logic        e_breq;
        logic        e_dsel;
        logic        e_idok;
        logic        e_ddok;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    function automatic vec_t mk(input logic rst, ireq, dreq, baok, bdok,
                                input logic [31:0] brdata,
                                input logic iaok, daok, breq, dsel, idok, ddok);
        vec_t v;
        v.rst = rst;    v.ireq = ireq;  v.dreq = dreq;
        v.baok = baok;  v.bdok = bdok;  v.brdata = brdata;
        v.e_iaok = iaok; v.e_daok = daok; v.e_breq = breq;
        v.e_dsel = dsel; v.e_idok = idok; v.e_ddok = ddok;
        return v;
    endfunction

    task automatic add(input logic rst, ireq, dreq, baok, bdok,
                       input logic [31:0] brdata,
                       input logic iaok, daok, breq, dsel, idok, ddok);
        vecs.push_back(mk(rst, ireq, dreq, baok, bdok, brdata,
                          iaok, daok, breq, dsel, idok, ddok));
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector after the falling edge, then check combinational outputs.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset             = v.rst;
        inst_if.req       = v.ireq;
        data_if.req       = v.dreq;
        bus_if.addr_ok    = v.baok;
        bus_if.data_ok    = v.bdok;
        bus_if.rdata      = v.brdata;
        #2;
        n_vec++;
        chk("inst_addr_ok", idx, 32'(inst_if.addr_ok), 32'(v.e_iaok));
        chk("data_addr_ok", idx, 32'(data_if.addr_ok), 32'(v.e_daok));
        chk("bus_req",      idx, 32'(bus_if.req),      32'(v.e_breq));
        chk("bus_addr",     idx, bus_if.addr,  v.e_dsel ? DA  : IA);
        chk("bus_wdata",    idx, bus_if.wdata, v.e_dsel ? DWD : IWD);
        chk("bus_wr",       idx, 32'(bus_if.wr),    v.e_dsel ? 32'd1 : 32'd0);
        chk("bus_size",     idx, 32'(bus_if.size),  v.e_dsel ? 32'd1 : 32'd2);
        chk("bus_wstrb",    idx, 32'(bus_if.wstrb), v.e_dsel ? 32'h3 : 32'hf);
        chk("inst_data_ok", idx, 32'(inst_if.data_ok), 32'(v.e_idok));
        chk("data_data_ok", idx, 32'(data_if.data_ok), 32'(v.e_ddok));
        if (v.e_idok) chk("inst_rdata", idx, inst_if.rdata, v.brdata);
        if (v.e_ddok) chk("data_rdata", idx, data_if.rdata, v.brdata);
    endtask

    initial begin
        inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2;
        inst_if.wstrb = 4'hf; inst_if.addr = IA; inst_if.wdata = IWD;
        data_if.req = 1'b0; data_if.wr = 1'b1; data_if.size = 2'd1;
        data_if.wstrb = 4'h3; data_if.addr = DA; data_if.wdata = DWD;
        bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = '0;

        //   rst ir dr aok dok rdata          iaok daok breq dsel idok ddok
        // reset and idle
        add(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1, 0, 0);
        // single fetch, response two cycles later
        add(0, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 32'h3c1d_8000,  0, 0, 0, 1, 1, 0);
        // both request: data first, inst next; responses in issue order
        add(0, 1, 1, 1, 0, 32'h0,          0, 1, 1, 1, 0, 0);
        add(0, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h1111_aaaa,  0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 32'h2222_bbbb,  0, 0, 0, 1, 1, 0);
        // data stalled three cycles, inst arrives; lock holds data
        add(0, 0, 1, 0, 0, 32'h0,          0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0, 32'h0,          0, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0, 32'h0,          0, 0, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0, 32'h0,          0, 0, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 32'h0,          0, 1, 1, 1, 0, 0);
        add(0, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hc1c1_c1c1,  0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 32'hc2c2_c2c2,  0, 0, 0, 1, 1, 0);
        // fill the owner FIFO: I, D, I, D
        add(0, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 32'h0,          0, 1, 1, 1, 0, 0);
        add(0, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 32'h0,          0, 1, 1, 1, 0, 0);
        // full: no grant, even on the popping cycle
        add(0, 1, 1, 1, 0, 32'h0,          0, 0, 0, 1, 0, 0);
        add(0, 1, 1, 1, 1, 32'hc3c3_c3c3,  0, 0, 0, 1, 1, 0);
        // slot freed: grant resumes next cycle (data, inst not yet starved)
        add(0, 1, 1, 1, 0, 32'h0,          0, 1, 1, 1, 0, 0);
        // drain D, I, D, D
        add(0, 0, 0, 0, 1, 32'h0000_0024,  0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 32'h0000_0025,  0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 32'h0000_0026,  0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 32'h0000_0027,  0, 0, 0, 1, 0, 1);
        // spurious response on empty FIFO
        add(0, 0, 0, 0, 1, 32'hdead_dead,  0, 0, 0, 1, 0, 0);
        // two outstanding, then reset discards them
        add(0, 1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 32'h0,          0, 1, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 32'hbeef_beef,  0, 0, 0, 1, 0, 0);

        foreach (vecs[i]) apply(vecs[i], i);

        // Starvation: data always requesting, one response per cycle keeps
        // the FIFO at depth one. Inst wins after 8 refusals, twice over.
        for (int c = 0; c < 19; c++) begin
            logic gi;
            logic idk;
            logic ddk;
            gi  = (c == 8) || (c == 17);
            idk = (c == 9) || (c == 18);
            ddk = (c >= 1) && !idk;
            apply(mk(0, 1, 1, 1, 1, 32'h5000_0000 + 32'(c),
                     gi, !gi, 1, !gi, idk, ddk), 100 + c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
